// File: rtl/conv_pkg.sv
// Shared types for the 3x3 convolution front end: FSM states, kernel size and
// the window-element index helper that the MAC also uses to pick its taps.
package conv_pkg;
    localparam int KERNEL_SIZE = 3;
    localparam int WIN_ELEMS   = KERNEL_SIZE * KERNEL_SIZE;

    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, CAP, OUT, DONE} state_t;

    // Element (r,c) of a packed window lives in slot 3r+c, LSB first.
    function automatic int win_idx(input int r, input int c);
        return KERNEL_SIZE * r + c;
    endfunction
endpackage

// File: rtl/bram_window_reader_if.sv
// Window reader bundle: bram read port, start/status and valid/ready window output.
// master = reader side, slave = bram/datapath/controller side.
interface bram_window_reader_if
    import conv_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int RAM_WIDTH  = 8,
    parameter int RAM_PORTS  = 3
);
    logic                            i_start;
    logic [RAM_WIDTH*RAM_PORTS-1:0]  i_data;
    logic                            i_ready;
    logic [ADDR_WIDTH*RAM_PORTS-1:0] o_r_addrs;
    logic [RAM_WIDTH*WIN_ELEMS-1:0]  o_window;
    logic                            o_valid;
    logic [ADDR_WIDTH-1:0]           o_row;
    logic [ADDR_WIDTH-1:0]           o_col;
    logic                            o_busy;
    logic                            o_done;

    modport master (
        input  i_start, i_data, i_ready,
        output o_r_addrs, o_window, o_valid, o_row, o_col, o_busy, o_done
    );

    modport slave (
        output i_start, i_data, i_ready,
        input  o_r_addrs, o_window, o_valid, o_row, o_col, o_busy, o_done
    );
endinterface

// File: rtl/window_addr_gen.sv
// Raster row/col counters plus 3-port bram address packing for one kernel row.
// Addresses are combinational from the post-update counters so they can be registered on the same edge.
module window_addr_gen
    import conv_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int RAM_PORTS  = 3,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            advance,
    input  logic [1:0]                      krow,
    output logic [ADDR_WIDTH-1:0]           row,
    output logic [ADDR_WIDTH-1:0]           col,
    output logic                            last,
    output logic [ADDR_WIDTH*RAM_PORTS-1:0] addrs
);
    localparam logic [ADDR_WIDTH-1:0] ROW_LEN = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] COL_MAX = ADDR_WIDTH'(IMG_W - KERNEL_SIZE);
    localparam logic [ADDR_WIDTH-1:0] ROW_MAX = ADDR_WIDTH'(IMG_H - KERNEL_SIZE);

    logic [ADDR_WIDTH-1:0] row_nxt;
    logic [ADDR_WIDTH-1:0] col_nxt;
    logic [ADDR_WIDTH-1:0] base;

    always_comb begin
        row_nxt = row;
        col_nxt = col;
        if (clear) begin
            row_nxt = '0;
            col_nxt = '0;
        end else if (advance) begin
            if (col == COL_MAX) begin
                col_nxt = '0;
                row_nxt = row + ADDR_WIDTH'(1);
            end else begin
                col_nxt = col + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else begin
            row <= row_nxt;
            col <= col_nxt;
        end
    end

    assign last = (row == ROW_MAX) && (col == COL_MAX);
    assign base = row_nxt * ROW_LEN + col_nxt + ADDR_WIDTH'(krow) * ROW_LEN;

    always_comb begin
        addrs = '0;
        for (int k = 0; k < RAM_PORTS; k++) begin
            addrs[ADDR_WIDTH*k +: ADDR_WIDTH] = base + ADDR_WIDTH'(k);
        end
    end
endmodule

// File: rtl/bram_window_reader.sv
// Scans a stored image into 3x3 windows: three 3-port bram reads per window, 5 cycles each.
// First o_valid 4 cycles after RD0 entry; holds in OUT while i_ready is low, issuing no new reads.
module bram_window_reader
    import conv_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int RAM_WIDTH  = 8,
    parameter int RAM_PORTS  = 3,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    bram_window_reader_if.master bus
);
    localparam int ROW_BITS = RAM_WIDTH * KERNEL_SIZE;

    generate
        if (RAM_PORTS != KERNEL_SIZE) begin : g_bad_ports
            $error("RAM_PORTS must equal the kernel width");
        end
        if (IMG_W < KERNEL_SIZE || IMG_H < KERNEL_SIZE) begin : g_bad_dims
            $error("image must be at least 3x3");
        end
        if (IMG_W * IMG_H > (1 << ADDR_WIDTH)) begin : g_bad_size
            $error("image does not fit in the bram address space");
        end
    endgenerate

    state_t                          state;
    state_t                          state_nxt;
    logic                            hs;
    logic                            last;
    logic                            load;
    logic [1:0]                      krow;
    logic [ADDR_WIDTH*RAM_PORTS-1:0] gen_addrs;
    logic [ADDR_WIDTH-1:0]           row;
    logic [ADDR_WIDTH-1:0]           col;

    assign hs = bus.o_valid && bus.i_ready;

    window_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .RAM_PORTS (RAM_PORTS),
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H)
    ) u_addr_gen (
        .clk    (i_clk),
        .rst    (i_rst),
        .clear  ((state == IDLE) && bus.i_start),
        .advance(hs && !last),
        .krow   (krow),
        .row    (row),
        .col    (col),
        .last   (last),
        .addrs  (gen_addrs)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        krow      = 2'd0;
        case (state)
            IDLE:    if (bus.i_start) state_nxt = RD0;
            RD0:     state_nxt = RD1;
            RD1:     state_nxt = RD2;
            RD2:     state_nxt = CAP;
            CAP:     state_nxt = OUT;
            OUT:     if (hs) state_nxt = last ? DONE : RD0;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Every RD state is always entered fresh, so the next state alone selects the kernel row.
        case (state_nxt)
            RD0:     begin load = 1'b1; krow = 2'd0; end
            RD1:     begin load = 1'b1; krow = 2'd1; end
            RD2:     begin load = 1'b1; krow = 2'd2; end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_r_addrs <= '0;
            bus.o_window  <= '0;
            bus.o_valid   <= 1'b0;
        end else begin
            if (load) bus.o_r_addrs <= gen_addrs;
            case (state)
                RD1: bus.o_window[RAM_WIDTH*win_idx(0, 0) +: ROW_BITS] <= bus.i_data;
                RD2: bus.o_window[RAM_WIDTH*win_idx(1, 0) +: ROW_BITS] <= bus.i_data;
                CAP: begin
                    bus.o_window[RAM_WIDTH*win_idx(2, 0) +: ROW_BITS] <= bus.i_data;
                    bus.o_valid <= 1'b1;
                end
                OUT:     if (bus.i_ready) bus.o_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.o_row  = row;
    assign bus.o_col  = col;
    assign bus.o_busy = (state != IDLE);
    assign bus.o_done = (state == DONE);
endmodule

// File: tb/tb_bram_window_reader.sv
// Bench for bram_window_reader: a 3x3 and an 8x8 instance, each fed by a 1-cycle-latency bram
// preloaded with pixel = address + 1; windows are compared against values computed from that rule.
module tb_bram_window_reader;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_window_reader_if #(.ADDR_WIDTH(6), .RAM_WIDTH(8), .RAM_PORTS(3)) b8 ();
    bram_window_reader_if #(.ADDR_WIDTH(6), .RAM_WIDTH(8), .RAM_PORTS(3)) b3 ();

    bram_window_reader #(.ADDR_WIDTH(6), .RAM_WIDTH(8), .RAM_PORTS(3), .IMG_W(8), .IMG_H(8))
        dut8 (.i_clk(clk), .i_rst(rst), .bus(b8));
    bram_window_reader #(.ADDR_WIDTH(6), .RAM_WIDTH(8), .RAM_PORTS(3), .IMG_W(3), .IMG_H(3))
        dut3 (.i_clk(clk), .i_rst(rst), .bus(b3));

    // bram models: one write port, three read ports, 1-cycle read latency
    logic [7:0] mem8 [64];
    logic [7:0] mem3 [9];
    logic       we = 1'b0;
    logic [5:0] wa = '0;
    logic [7:0] wd = '0;

    always @(posedge clk) begin
        if (we) begin
            mem8[wa] <= wd;
            if (wa < 6'd9) mem3[wa[3:0]] <= wd;
        end
        for (int k = 0; k < 3; k++) begin
            b8.i_data[8*k +: 8] <= mem8[b8.o_r_addrs[6*k +: 6]];
            b3.i_data[8*k +: 8] <= mem3[b3.o_r_addrs[6*k +: 4]];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [71:0] win;
        logic [5:0]  row;
        logic [5:0]  col;
        int          at;
    } cap_t;

    cap_t cap_q[$];
    int   done_cnt = 0;
    int   done_cyc = 0;

    always @(negedge clk) begin
        if (b8.o_valid && b8.i_ready) cap_q.push_back('{b8.o_window, b8.o_row, b8.o_col, cyc});
        if (b8.o_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chkw(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Window whose top-left pixel is (r0,c0) in a w-wide image holding pixel = addr + 1.
    function automatic logic [71:0] exp_win(input int w, input int r0, input int c0);
        logic [71:0] v;
        v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[8*(3*r+c) +: 8] = 8'((r0 + r) * w + c0 + c + 1);
        return v;
    endfunction

    task automatic chk_zero8(input string tag);
        chki({tag, "_addrs"}, int'(b8.o_r_addrs), 0);
        chkw({tag, "_window"}, b8.o_window, 72'h0);
        chki({tag, "_valid"}, int'(b8.o_valid), 0);
        chki({tag, "_row"}, int'(b8.o_row), 0);
        chki({tag, "_col"}, int'(b8.o_col), 0);
        chki({tag, "_busy"}, int'(b8.o_busy), 0);
        chki({tag, "_done"}, int'(b8.o_done), 0);
    endtask

    task automatic pulse_start8(output int s);
        b8.i_start = 1'b1;
        tick();
        b8.i_start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_done8(input int d0, input int budget);
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
        chki("done_seen", int'(done_cnt != d0), 1);
    endtask

    // Every accepted window since cap_q index base must follow raster order exactly once.
    task automatic check_scan(input string tag, input int base);
        int n;
        n = cap_q.size() - base;
        chki({tag, "_count"}, n, 36);
        for (int i = 0; i < n && i < 36; i++) begin
            chkw({tag, "_win"}, cap_q[base+i].win, exp_win(8, i / 6, i % 6));
            chki({tag, "_pos"}, int'({cap_q[base+i].row, cap_q[base+i].col}), ((i / 6) << 6) | (i % 6));
        end
    endtask

    typedef struct {
        logic [17:0] addrs;
        logic        valid;
        logic        busy;
        logic        done;
        logic        win_chk;
        logic [71:0] win;
    } vec3_t;

    typedef struct {
        int          idx;
        int          row;
        int          col;
        logic [71:0] win;
    } vec8_t;

    vec3_t       t3[7];
    vec8_t       t8[4];
    int          s, base, d0, bad, stall_left;
    bit          stalled, found;
    logic [71:0] snap_win;
    logic [17:0] snap_addr;

    initial begin
        t3[0] = '{{6'd2, 6'd1, 6'd0}, 1'b0, 1'b1, 1'b0, 1'b0, 72'h0};
        t3[1] = '{{6'd5, 6'd4, 6'd3}, 1'b0, 1'b1, 1'b0, 1'b0, 72'h0};
        t3[2] = '{{6'd8, 6'd7, 6'd6}, 1'b0, 1'b1, 1'b0, 1'b1, 72'h030201};
        t3[3] = '{{6'd8, 6'd7, 6'd6}, 1'b0, 1'b1, 1'b0, 1'b1, 72'h060504_030201};
        t3[4] = '{{6'd8, 6'd7, 6'd6}, 1'b1, 1'b1, 1'b0, 1'b1, 72'h090807060504030201};
        t3[5] = '{{6'd8, 6'd7, 6'd6}, 1'b0, 1'b1, 1'b1, 1'b0, 72'h0};
        t3[6] = '{{6'd8, 6'd7, 6'd6}, 1'b0, 1'b0, 1'b0, 1'b0, 72'h0};
        t8[0] = '{0,  0, 0, 72'h131211_0B0A09_030201};
        t8[1] = '{5,  0, 5, 72'h181716_100F0E_080706};
        t8[2] = '{6,  1, 0, 72'h1B1A19_131211_0B0A09};
        t8[3] = '{35, 5, 5, 72'h403F3E_383736_302F2E};

        b8.i_start = 1'b0; b8.i_ready = 1'b0;
        b3.i_start = 1'b0; b3.i_ready = 1'b0;

        for (int a = 0; a < 64; a++) begin
            wa = 6'(a); wd = 8'(a + 1); we = 1'b1;
            tick();
        end
        we = 1'b0;

        @(negedge clk);
        chk_zero8("reset");
        chki("reset3_addrs", int'(b3.o_r_addrs), 0);
        chkw("reset3_window", b3.o_window, 72'h0);
        chki("reset3_busy", int'(b3.o_busy), 0);

        // start coinciding with reset must be lost
        tick();
        b8.i_start = 1'b1;
        tick();
        b8.i_start = 1'b0;
        rst = 1'b0;
        tick();
        @(negedge clk);
        chki("rst_start_busy", int'(b8.o_busy), 0);
        tick();

        // 3x3 image: cycle-by-cycle table from RD0 entry
        b3.i_ready = 1'b1;
        b3.i_start = 1'b1;
        tick();
        b3.i_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chki("t3_addrs", int'(b3.o_r_addrs), int'(t3[i].addrs));
            chki("t3_valid", int'(b3.o_valid), int'(t3[i].valid));
            chki("t3_busy", int'(b3.o_busy), int'(t3[i].busy));
            chki("t3_done", int'(b3.o_done), int'(t3[i].done));
            if (t3[i].win_chk) chkw("t3_window", b3.o_window, t3[i].win);
        end
        tick();

        // Scan A: 8x8 with i_ready held high
        b8.i_ready = 1'b1;
        base = cap_q.size();
        d0 = done_cnt;
        pulse_start8(s);
        wait_done8(d0, 400);
        @(negedge clk);
        chki("A_busy_after", int'(b8.o_busy), 0);
        chki("A_done_after", int'(b8.o_done), 0);
        check_scan("A", base);
        for (int i = 0; i < 4; i++) begin
            if (base + t8[i].idx < cap_q.size()) begin
                chkw("A_table_win", cap_q[base+t8[i].idx].win, t8[i].win);
                chki("A_table_row", int'(cap_q[base+t8[i].idx].row), t8[i].row);
                chki("A_table_col", int'(cap_q[base+t8[i].idx].col), t8[i].col);
            end
        end
        if (cap_q.size() > base) begin
            chki("A_first_latency", cap_q[base].at - s, 4);
            bad = 0;
            for (int i = base + 1; i < cap_q.size(); i++)
                if (cap_q[i].at - cap_q[i-1].at != 5) bad++;
            chki("A_spacing", bad, 0);
            chki("A_done_timing", done_cyc - cap_q[cap_q.size()-1].at, 1);
        end
        chki("A_done_count", done_cnt - d0, 1);
        tick();

        // Scan B: random ready, a 7-cycle stall on (0,1), stray starts while busy
        base = cap_q.size();
        d0 = done_cnt;
        stall_left = 0;
        stalled = 1'b0;
        b8.i_ready = 1'b0;
        pulse_start8(s);
        for (int i = 0; i < 2000 && done_cnt == d0; i++) begin
            if (stall_left > 0) begin
                chki("B_stall_valid", int'(b8.o_valid), 1);
                chkw("B_stall_window", b8.o_window, snap_win);
                chki("B_stall_addrs", int'(b8.o_r_addrs), int'(snap_addr));
                chki("B_stall_pos", int'({b8.o_row, b8.o_col}), 1);
                b8.i_ready = 1'b0;
                stall_left--;
            end else if (!stalled && b8.o_valid && b8.o_row == 6'd0 && b8.o_col == 6'd1) begin
                snap_win = b8.o_window;
                snap_addr = b8.o_r_addrs;
                b8.i_ready = 1'b0;
                stall_left = 6;
                stalled = 1'b1;
            end else begin
                b8.i_ready = ($urandom_range(0, 3) != 0);
            end
            b8.i_start = b8.o_busy && !b8.o_done && ($urandom_range(0, 5) == 0);
            tick();
        end
        b8.i_start = 1'b0;
        chki("B_done_seen", int'(done_cnt != d0), 1);
        chki("B_stalled", int'(stalled), 1);
        @(negedge clk);
        chki("B_busy_after", int'(b8.o_busy), 0);
        check_scan("B", base);
        repeat (10) tick();
        chki("B_done_count", done_cnt - d0, 1);

        // Scan C: reset while window (2,3) is presented, then restart
        b8.i_ready = 1'b1;
        d0 = done_cnt;
        pulse_start8(s);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (b8.o_valid && b8.o_row == 6'd2 && b8.o_col == 6'd3) found = 1'b1;
            else tick();
        end
        chki("C_reached_2_3", int'(found), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_zero8("midreset");
        repeat (10) tick();
        chki("C_no_done", done_cnt - d0, 0);
        chki("C_idle", int'(b8.o_busy), 0);
        base = cap_q.size();
        pulse_start8(s);
        wait_done8(d0, 400);
        @(negedge clk);
        chki("C_busy_after", int'(b8.o_busy), 0);
        check_scan("C", base);
        if (cap_q.size() > base) chki("C_first_latency", cap_q[base].at - s, 4);
        chki("C_done_count", done_cnt - d0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
